// File: rtl/spi_master_ctrl_if.sv
// Host-side bus of the SPI master controller: the request handshake, the
// per-word mode controls and the completion status.
// The host drives through the master modport; the controller uses the slave modport.
interface spi_master_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start_i;
    logic [DATA_WIDTH-1:0] tx_data_i;
    logic                  cpol_i;
    logic                  cpha_i;
    logic                  lsb_first_i;
    logic                  hold_cs_i;
    logic [DATA_WIDTH-1:0] rx_data_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        output start_i, tx_data_i, cpol_i, cpha_i, lsb_first_i, hold_cs_i,
        input  rx_data_o, busy_o, done_o
    );

    modport slave (
        input  start_i, tx_data_i, cpol_i, cpha_i, lsb_first_i, hold_cs_i,
        output rx_data_o, busy_o, done_o
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master controller: serialises DATA_WIDTH-bit words on MOSI while capturing
// MISO, with per-word CPOL/CPHA, bit order and chip-select hold for bursts.
// SCK half-period is CLK_DIV sysClk_i cycles; one active-low chip select.
// Build option: define SPI_LOOPBACK_EN to feed the MISO sampling path from
// SPI_MOSI_o instead of SPI_MISO_i (the pins are still driven).
module spi_master_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2
) (
    input  logic                sysClk_i,
    input  logic                reset_i,
    spi_master_ctrl_if.slave    bus,
    output logic                SPI_Clk_o,
    output logic                SPI_MOSI_o,
    input  logic                SPI_MISO_i,
    output logic                SPI_CS_o_n
);

    localparam int EW   = $clog2(2 * DATA_WIDTH + 1);
    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [EW-1:0]   LAST_EDGE = EW'(2 * DATA_WIDTH);
    localparam logic [DIVW-1:0] DIV_MAX   = DIVW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_LAST,
        ST_CS_HELD
    } state_t;

    state_t                state_q, state_d;
    logic [DIVW-1:0]       div_q, div_d;
    logic [EW-1:0]         edge_q, edge_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic                  lsb_q, lsb_d;
    logic                  phase_q, phase_d;
    logic                  miso_q, miso_d;

    logic                  accept;
    logic                  div_done;
    logic                  done;
    logic [EW-1:0]         edge_n;
    logic                  sample_edge;

`ifdef SPI_LOOPBACK_EN
    assign miso_d = SPI_MOSI_o;
`else
    assign miso_d = SPI_MISO_i;
`endif

    assign accept      = bus.start_i && ((state_q == ST_IDLE) || (state_q == ST_CS_HELD));
    assign div_done    = (div_q == DIV_MAX);
    assign edge_n      = edge_q + EW'(1);
    // Odd edges sample in CPHA=0, even edges sample in CPHA=1.
    assign sample_edge = edge_n[0] ^ cpha_q;
    assign done        = (state_q == ST_LAST) && div_done;

    // Next-state, shifter and SCK phase computation.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        edge_d  = edge_q;
        tx_d    = tx_q;
        rx_sh_d = rx_sh_q;
        rx_d    = rx_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        lsb_d   = lsb_q;
        phase_d = phase_q;

        case (state_q)
            ST_IDLE: begin
                // Track CPOL while idle so SCK already rests at the right level.
                cpol_d  = bus.cpol_i;
                phase_d = 1'b0;
                if (accept) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (div_done) begin
                    div_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end
            ST_SHIFT: begin
                if (div_done) begin
                    div_d   = '0;
                    edge_d  = edge_n;
                    phase_d = ~phase_q;
                    if (sample_edge) begin
                        rx_sh_d = lsb_q ? {miso_q, rx_sh_q[DATA_WIDTH-1:1]}
                                        : {rx_sh_q[DATA_WIDTH-2:0], miso_q};
                    end else if ((edge_n != EW'(1)) && (edge_n != LAST_EDGE)) begin
                        // The first bit is already on MOSI since accept; the
                        // last trailing edge has no next bit to present.
                        tx_d = lsb_q ? (tx_q >> 1) : (tx_q << 1);
                    end
                    if (edge_n == LAST_EDGE) begin
                        state_d = ST_LAST;
                    end
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end
            ST_LAST: begin
                if (div_done) begin
                    div_d   = '0;
                    rx_d    = rx_sh_q;
                    state_d = bus.hold_cs_i ? ST_CS_HELD : ST_IDLE;
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end
            ST_CS_HELD: begin
                phase_d = 1'b0;
                if (accept) begin
                    state_d = ST_SHIFT;
                end else if (!bus.hold_cs_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Word acceptance (only possible in IDLE or CS_HELD).
        if (accept) begin
            tx_d   = bus.tx_data_i;
            cpol_d = bus.cpol_i;
            cpha_d = bus.cpha_i;
            lsb_d  = bus.lsb_first_i;
            div_d  = '0;
            edge_d = '0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge sysClk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            edge_q  <= '0;
            tx_q    <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            phase_q <= 1'b0;
            miso_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            tx_q    <= tx_d;
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            phase_q <= phase_d;
            miso_q  <= miso_d;
        end
    end

    assign SPI_Clk_o     = cpol_q ^ phase_q;
    assign SPI_MOSI_o    = lsb_q ? tx_q[0] : tx_q[DATA_WIDTH-1];
    assign SPI_CS_o_n    = (state_q == ST_IDLE);
    assign bus.done_o    = done;
    assign bus.busy_o    = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                           (state_q == ST_LAST) || accept;
    // The completed word is visible in the done cycle and held afterwards.
    assign bus.rx_data_o = done ? rx_sh_q : rx_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl (DATA_WIDTH=8, CLK_DIV=2) with an SPI
// slave model that returns a chosen word and logs MOSI at its sampling edges.
module tb_spi_master_ctrl;

    localparam int N = 8;
    localparam int D = 2;

    logic clk;
    logic rst;
    logic sck, mosi, miso, cs_n;

    spi_master_ctrl_if #(.DATA_WIDTH(N)) bus_if ();

    spi_master_ctrl #(.DATA_WIDTH(N), .CLK_DIV(D)) dut (
        .sysClk_i   (clk),
        .reset_i    (rst),
        .bus        (bus_if),
        .SPI_Clk_o  (sck),
        .SPI_MOSI_o (mosi),
        .SPI_MISO_i (miso),
        .SPI_CS_o_n (cs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model configuration, set by the tasks.
    logic       cur_cpol = 1'b0;
    logic       cur_cpha = 1'b0;
    logic       cur_lsb  = 1'b0;
    logic [7:0] slave_word = 8'h00;

    // Slave model state.
    int   lead_cnt = 0;
    int   trail_cnt = 0;
    int   mosi_wp = 0;
    logic mosi_log [0:63];
    logic prev_sck = 1'b0;

    // Slave: shifts on its shift edge, logs MOSI on its sampling edge.
    always @(negedge clk) begin : slave_model
        int l, t, wp, idx;
        logic b;
        l  = lead_cnt;
        t  = trail_cnt;
        wp = mosi_wp;
        if (cs_n !== 1'b0) begin
            l = 0;
            t = 0;
        end else if (sck !== prev_sck) begin
            if (sck !== cur_cpol) begin
                l = l + 1;
                if (!cur_cpha) begin
                    mosi_log[wp % 64] <= mosi;
                    wp = wp + 1;
                end
            end else begin
                t = t + 1;
                if (cur_cpha) begin
                    mosi_log[wp % 64] <= mosi;
                    wp = wp + 1;
                end
                if (t == N) begin
                    l = 0;
                    t = 0;
                end
            end
        end
        idx = cur_cpha ? ((l == 0) ? 0 : l - 1) : t;
        b   = slave_word[cur_lsb ? idx : (N - 1 - idx)];
`ifdef SPI_LOOPBACK_EN
        miso <= 1'b0;
`else
        miso <= (cs_n === 1'b0) ? b : 1'b0;
`endif
        lead_cnt  <= l;
        trail_cnt <= t;
        mosi_wp   <= wp;
        prev_sck  <= sck;
    end

    // One word: optional start injected mid-word (inject_at) or in the done cycle.
    task automatic run_word(input string tag, input logic [7:0] tx, input logic [7:0] sw,
                            input logic cpol, input logic cpha, input logic lsb,
                            input logic hold, input bit from_held,
                            input int inject_at, input bit inject_done);
        int         wp0, lat, exp_lat, nbits;
        logic [7:0] exp_rx, seen, exp_seq;
        logic       exp_cs;
        bit         cs_ok;
        exp_lat = from_held ? (2 * N + 1) * D : (2 * N + 2) * D;
`ifdef SPI_LOOPBACK_EN
        exp_rx = tx;
`else
        exp_rx = sw;
`endif
        for (int i = 0; i < N; i++) exp_seq[i] = lsb ? tx[i] : tx[N - 1 - i];
        cur_cpol = cpol; cur_cpha = cpha; cur_lsb = lsb; slave_word = sw;
        bus_if.cpol_i = cpol; bus_if.cpha_i = cpha; bus_if.lsb_first_i = lsb;
        repeat (2) @(negedge clk);
        exp_cs = from_held ? 1'b0 : 1'b1;
        n_checks++;
        if (cs_n !== exp_cs) begin
            n_fail++;
            $display("FAIL %s cs_before_start: got %b expected %b", tag, cs_n, exp_cs);
        end
        if (!from_held) begin
            n_checks++;
            if (sck !== cpol) begin
                n_fail++;
                $display("FAIL %s sck_idle: got %b expected %b", tag, sck, cpol);
            end
        end
        wp0 = mosi_wp;
        bus_if.hold_cs_i = hold;
        bus_if.tx_data_i = tx;
        bus_if.start_i   = 1'b1;
        #1;
        n_checks++;
        if (bus_if.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_accept: got %b expected 1", tag, bus_if.busy_o);
        end
        @(posedge clk);
        #1;
        bus_if.start_i   = 1'b0;
        bus_if.tx_data_i = 8'($urandom);
        lat   = 0;
        cs_ok = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (cs_n !== 1'b0) cs_ok = 1'b0;
            if (bus_if.done_o === 1'b1) begin
                lat = k;
                break;
            end
            if (k == inject_at) begin
                bus_if.start_i   = 1'b1;
                bus_if.tx_data_i = ~tx;
                @(posedge clk);
                #1;
                bus_if.start_i = 1'b0;
            end
        end
        n_checks++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s done_latency: got %0d expected %0d", tag, lat, exp_lat);
        end
        n_checks++;
        if (!cs_ok) begin
            n_fail++;
            $display("FAIL %s cs_low_during_word: got high expected low", tag);
        end
        n_checks++;
        if (bus_if.rx_data_o !== exp_rx || bus_if.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s rx_at_done: got rx=%h busy=%b expected rx=%h busy=1",
                     tag, bus_if.rx_data_o, bus_if.busy_o, exp_rx);
        end
        nbits = mosi_wp - wp0;
        for (int i = 0; i < N; i++) seen[i] = mosi_log[(wp0 + i) % 64];
        n_checks++;
        if (nbits != N || seen !== exp_seq) begin
            n_fail++;
            $display("FAIL %s mosi_bits: got %0d bits seq=%b expected %0d bits seq=%b (bit0 first)",
                     tag, nbits, seen, N, exp_seq);
        end
        if (inject_done) begin
            bus_if.start_i   = 1'b1;
            bus_if.tx_data_i = 8'($urandom);
            @(posedge clk);
            #1;
            bus_if.start_i = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (bus_if.done_o !== 1'b0 || bus_if.busy_o !== 1'b0 ||
            bus_if.rx_data_o !== exp_rx || cs_n !== ~hold) begin
            n_fail++;
            $display("FAIL %s after_done: got done=%b busy=%b rx=%h cs_n=%b expected 0 0 %h %b",
                     tag, bus_if.done_o, bus_if.busy_o, bus_if.rx_data_o, cs_n, exp_rx, ~hold);
        end
        $display("word %s: tx=%h cpol=%b cpha=%b lsb=%b hold=%b rx=%h latency=%0d",
                 tag, tx, cpol, cpha, lsb, hold, bus_if.rx_data_o, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (cs_n !== 1'b1 || sck !== 1'b0 || mosi !== 1'b0 || bus_if.busy_o !== 1'b0 ||
            bus_if.done_o !== 1'b0 || bus_if.rx_data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: got cs_n=%b sck=%b mosi=%b busy=%b done=%b rx=%h expected 1 0 0 0 0 00",
                     cs_n, sck, mosi, bus_if.busy_o, bus_if.done_o, bus_if.rx_data_o);
        end
        rst = 1'b0;
        $display("reset: cs_n=%b sck=%b busy=%b", cs_n, sck, bus_if.busy_o);
    endtask

    task automatic test_mode0();
        run_word("mode0", 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_mode3();
        run_word("mode3_lsb", 8'h81, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_word("random", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'b0, 1'b0, 0, 1'b0);
        end
    endtask

    task automatic test_burst();
        run_word("burst1", 8'h12, 8'h9E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run_word("burst2", 8'h34, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        run_word("burst3", 8'h56, 8'hD2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        // Drop hold without a start: CS releases next cycle.
        bus_if.hold_cs_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cs_n !== 1'b1 || bus_if.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_drop: got cs_n=%b busy=%b expected 1 0", cs_n, bus_if.busy_o);
        end
        $display("hold_drop: cs_n=%b", cs_n);
    endtask

    task automatic test_start_ignored();
        int dones;
        run_word("start_midword", 8'hC7, 8'h5B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus_if.done_o === 1'b1 || bus_if.busy_o === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL start_midword_extra_activity: got %0d cycles busy/done expected 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        run_word("start_in_done", 8'h3E, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        run_word("after_done", 8'hE3, 8'h1A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_midword();
        int dones;
        cur_cpol = 1'b0; cur_cpha = 1'b0; cur_lsb = 1'b0; slave_word = 8'hFF;
        bus_if.cpol_i = 1'b0; bus_if.cpha_i = 1'b0; bus_if.lsb_first_i = 1'b0;
        bus_if.hold_cs_i = 1'b0;
        repeat (2) @(negedge clk);
        bus_if.tx_data_i = 8'hC3;
        bus_if.start_i   = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start_i = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cs_n !== 1'b1 || sck !== 1'b0 || bus_if.busy_o !== 1'b0 ||
            bus_if.done_o !== 1'b0 || bus_if.rx_data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_midword: got cs_n=%b sck=%b busy=%b done=%b rx=%h expected 1 0 0 0 00",
                     cs_n, sck, bus_if.busy_o, bus_if.done_o, bus_if.rx_data_o);
        end
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus_if.done_o === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL reset_midword_no_done: got %0d done pulses expected 0", dones);
        end
        $display("reset_midword: cs_n=%b sck=%b dones=%0d", cs_n, sck, dones);
        run_word("after_reset", 8'h66, 8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus_if.start_i     = 1'b0;
        bus_if.tx_data_i   = 8'h00;
        bus_if.cpol_i      = 1'b0;
        bus_if.cpha_i      = 1'b0;
        bus_if.lsb_first_i = 1'b0;
        bus_if.hold_cs_i   = 1'b0;
        test_reset();
        test_mode0();
        test_mode3();
        test_random();
        test_burst();
        test_start_ignored();
        test_back_to_back();
        test_reset_midword();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
